// File: rtl/user_counter_la.sv
// Wishbone/LA user counter: 32-bit free-running COUNT with per-bit LA override and a 16-bit CHECK reg on io_out.
// Optional feature macro LA_SOFT_RESET_EN: la_oenb[0]=0 with la_data_in[0]=1 synchronously clears COUNT.

module user_counter_la_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             clr,
  input  logic [VEC_W-1:0] ov,
  input  logic [VEC_W-1:0] la_val,
  input  logic             wr,
  input  logic [VEC_W-1:0] wdata,
  input  logic [VEC_W-1:0] inc,
  output logic [VEC_W-1:0] q
);
  logic [VEC_W-1:0] base;

  assign base = wr ? wdata : inc;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb)  q <= '0;
    else if (clr) q <= '0;
    else          q <= (ov & la_val) | (~ov & base);
  end
endmodule

module user_counter_la #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  input  logic [63:0] la_data_in,
  input  logic [63:0] la_oenb,
  output logic [63:0] la_data_out,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);
  localparam logic [1:0] REG_COUNT = 2'd0;
  localparam logic [1:0] REG_CHECK = 2'd1;
  localparam int         CHK_LANES = 2;

  typedef struct packed {
    logic        we;
    logic [1:0]  reg_sel;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

  wb_req_t                                req;
  logic                                   req_new;
  logic                                   wr_cmt;
  logic                                   ack_q;
  logic [31:0]                            rdata_q;
  logic [31:0]                            rd_mux;
  logic                                   soft_clr;
  logic [NUM_LANES-1:0][VEC_W-1:0]        count;
  logic [NUM_LANES-1:0][VEC_W-1:0]        count_inc;
  logic [CHK_LANES-1:0][VEC_W-1:0]        check;
  logic                                   unused_bits;

  assign req = '{we: wb_we, reg_sel: wb_adr[3:2], sel: wb_sel, dat: wb_dat_i};

  // A request is new only while ack is low, which forces an idle cycle between acks.
  assign req_new = wb_cyc & wb_stb & ~ack_q;
  // Writes commit at the end of the ack cycle, so a reset during the transfer drops it.
  assign wr_cmt  = ack_q & wb_cyc & wb_stb & req.we;

  assign count_inc = count + 32'd1;

`ifdef LA_SOFT_RESET_EN
  assign soft_clr = ~la_oenb[0] & la_data_in[0];
`else
  assign soft_clr = 1'b0;
`endif

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_cnt
      user_counter_la_lane #(.VEC_W(VEC_W)) u_lane (
        .clock  (clock),
        .resetb (resetb),
        .clr    (soft_clr),
        .ov     (~la_oenb[32+l*VEC_W +: VEC_W]),
        .la_val (la_data_in[32+l*VEC_W +: VEC_W]),
        .wr     (wr_cmt & (req.reg_sel == REG_COUNT) & req.sel[l]),
        .wdata  (req.dat[l*VEC_W +: VEC_W]),
        .inc    (count_inc[l]),
        .q      (count[l])
      );
    end

    // CHECK reuses the lane cell with no override and a hold in place of increment.
    for (l = 0; l < CHK_LANES; l++) begin : g_chk
      user_counter_la_lane #(.VEC_W(VEC_W)) u_lane (
        .clock  (clock),
        .resetb (resetb),
        .clr    (1'b0),
        .ov     ('0),
        .la_val ('0),
        .wr     (wr_cmt & (req.reg_sel == REG_CHECK) & req.sel[l]),
        .wdata  (req.dat[l*VEC_W +: VEC_W]),
        .inc    (check[l]),
        .q      (check[l])
      );
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (req.reg_sel)
      REG_COUNT: rd_mux = count;
      REG_CHECK: rd_mux = {16'h0, check};
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= req_new;
      rdata_q <= req_new ? rd_mux : '0;
    end
  end

  assign wb_ack      = ack_q;
  assign wb_dat_o    = rdata_q;
  assign la_data_out = {32'h0, count};
  assign io_out      = {6'h0, check, 16'h0};
  assign io_oeb      = {6'h3F, 16'h0, 16'hFFFF};

  assign unused_bits = &{1'b0, wb_adr[31:4], wb_adr[1:0], la_oenb[31:0], la_data_in[31:0]};
endmodule

// File: tb/tb_user_counter_la.sv
// Scoreboard bench for user_counter_la: expectations queued at drive time, popped when outputs are sampled.
module tb_user_counter_la;
  logic        clock = 1'b0;
  logic        resetb;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
  logic        wb_ack;
  logic [63:0] la_data_in, la_oenb, la_data_out;
  logic [37:0] io_out, io_oeb;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  always #5 clock = ~clock;

  user_counter_la dut (
    .clock(clock), .resetb(resetb),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .la_data_in(la_data_in), .la_oenb(la_oenb), .la_data_out(la_data_out),
    .io_out(io_out), .io_oeb(io_oeb)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got %h with empty scoreboard", tag, got);
    end else begin
      chk(tag, {32'h0, got}, {32'h0, exp_q.pop_front()});
    end
  endtask

  // Entered #1 after a rising edge; returns #1 after the edge that ends the ack cycle.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat; wb_sel = sel;
    @(posedge clock); #1;
    chk("ack_rise", {63'h0, wb_ack}, 64'h1);
    rdat = wb_dat_o;
    @(posedge clock); #1;
    chk("ack_single", {63'h0, wb_ack}, 64'h0);
    chk("dat_o_idle", {32'h0, wb_dat_o}, 64'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic la_preset(input logic [31:0] v);
    la_oenb    = {32'h0, 32'hFFFF_FFFF};
    la_data_in = {v, 32'h0};
    @(posedge clock); #1;
  endtask

  task automatic la_release();
    la_oenb    = '1;
    la_data_in = '0;
  endtask

  initial begin
    resetb = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = '0;
    wb_adr = '0; wb_dat_i = '0; la_oenb = '1; la_data_in = '0;
    #12;
    chk("rst_count", la_data_out, 64'h0);
    chk("rst_ack", {63'h0, wb_ack}, 64'h0);
    chk("rst_dat_o", {32'h0, wb_dat_o}, 64'h0);
    chk("rst_io_out", {26'h0, io_out}, 64'h0);
    chk("rst_io_oeb", {26'h0, io_oeb}, 64'h0000_003F_0000_FFFF);
    resetb = 1'b1;
    @(posedge clock); #1;
    push(32'h1); pop_chk("resume_count", la_data_out[31:0]);

    // CHECK write/readback and byte lanes
    wb_xfer(1'b1, 32'h4, 32'h0000_AB40, 4'hF, rd);
    push(32'hAB40); pop_chk("io_check", {16'h0, io_out[31:16]});
    wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd);
    push(32'h0000_AB40); pop_chk("rd_check", rd);
    wb_xfer(1'b1, 32'h4, 32'hFFFF_CD00, 4'b0010, rd);
    wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd);
    push(32'h0000_CD40); pop_chk("rd_check_lane", rd);
    wb_xfer(1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, rd);
    wb_xfer(1'b0, 32'h8, 32'h0, 4'hF, rd);
    push(32'h0); pop_chk("rd_adr2", rd);
    wb_xfer(1'b0, 32'hC, 32'h0, 4'hF, rd);
    push(32'h0); pop_chk("rd_adr3", rd);
    push(32'hCD40); pop_chk("check_after_bad_wr", {16'h0, io_out[31:16]});

    // held request: ack, gap, ack
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h4;
    for (int i = 0; i < 3; i++) push((i == 1) ? 32'h0 : 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      pop_chk("held_ack", {31'h0, wb_ack});
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clock); #1;

    // COUNT write with low byte LA-overridden
    la_oenb    = ~(64'hFF << 32);
    la_data_in = 64'hAA << 32;
    wb_xfer(1'b1, 32'h0, 32'h1234_5678, 4'hF, rd);
    push(32'h1234_56AA); pop_chk("wr_la_merge", la_data_out[31:0]);
    @(posedge clock); #1;
    push(32'h1234_56AA); pop_chk("la_byte_hold", la_data_out[31:0]);
    la_release();
    @(posedge clock); #1;
    push(32'h1234_56AB); pop_chk("inc_after_la", la_data_out[31:0]);
    wb_xfer(1'b0, 32'h0, 32'h0, 4'hF, rd);
    push(32'h1234_56AB); pop_chk("rd_count", rd);

    // async reset mid-count
    la_preset(32'h100);
    push(32'h100); pop_chk("preset_100", la_data_out[31:0]);
    #2 resetb = 1'b0;
    #1;
    chk("async_count", la_data_out, 64'h0);
    chk("async_check", {48'h0, io_out[31:16]}, 64'h0);
    la_release();
    #1 resetb = 1'b1;
    @(posedge clock); #1;
    push(32'h1); pop_chk("post_rst_count", la_data_out[31:0]);

    // reset abandons a write in flight
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h4; wb_dat_i = 32'h9999; wb_sel = 4'hF;
    @(posedge clock); #1;
    chk("abandon_ack_rise", {63'h0, wb_ack}, 64'h1);
    resetb = 1'b0;
    #1;
    chk("abandon_ack", {63'h0, wb_ack}, 64'h0);
    chk("abandon_dat_o", {32'h0, wb_dat_o}, 64'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    #1 resetb = 1'b1;
    @(posedge clock); #1;
    chk("abandon_no_wr", {48'h0, io_out[31:16]}, 64'h0);

    // LA hold at zero, then count up
    la_oenb = {32'h0, 32'hFFFF_FFFF}; la_data_in = '0;
    repeat (5) @(posedge clock);
    #1 la_release();
    for (int i = 0; i < 4; i++) push(i);
    pop_chk("la_zero", la_data_out[31:0]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      pop_chk("la_countup", la_data_out[31:0]);
    end

    // wrap
    la_preset(32'hFFFF_FFFE);
    la_release();
    push(32'hFFFF_FFFE); push(32'hFFFF_FFFF); push(32'h0);
    pop_chk("wrap_pre", la_data_out[31:0]);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      pop_chk("wrap", la_data_out[31:0]);
    end

    // soft reset via LA bit 0
    la_preset(32'h50);
    push(32'h50); pop_chk("soft_pre", la_data_out[31:0]);
    la_oenb = 64'hFFFF_FFFF_FFFF_FFFE; la_data_in = 64'h1;
`ifdef LA_SOFT_RESET_EN
    push(32'h0);
`else
    push(32'h51);
`endif
    @(posedge clock); #1;
    pop_chk("soft_rst", la_data_out[31:0]);
    la_release();
    chk("la_hi_zero", {32'h0, la_data_out[63:32]}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
